// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared FSM encoding and constants for the data-memory responder.
package data_mem_responder_pkg;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;
    localparam logic [31:0] DMEM_ERR_PATTERN = 32'hDEAD_BEEF;
    localparam int          DMEM_MAX_WAIT    = 15;
endpackage

// File: rtl/dmem_sram_bank.sv
// dmem_sram_bank: single-port synchronous RAM, 4 byte write enables, write-before-read, registered read.
// Ports: clk_i, rst_n_i (resets only the read register), addr_i word index,
//        we_i byte enables, re_i read strobe, wdata_i, rdata_o (holds until the next read).
module dmem_sram_bank #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            we_i,
    input  logic                  re_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);
    logic [31:0] mem_q [2**ADDR_WIDTH];
    logic [31:0] merged;
    logic [31:0] rdata_q;

    // The post-write word feeds both the array and the read register, so a
    // combined read/write returns the freshly written bytes.
    always_comb begin
        merged = mem_q[addr_i];
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = we_i[i] ? wdata_i[8*i +: 8] : merged[8*i +: 8];
    end

    always_ff @(posedge clk_i)
        if (|we_i) mem_q[addr_i] <= merged;

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) rdata_q <= '0;
        else if (re_i) rdata_q <= merged;

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-memory responder with wait states and a one-cycle Ready pulse.
// Ports: clock, reset_n (async, active-low), ReadEnable, WriteEnable[3:0] byte lanes,
//        Address (byte address, word = [ADDR_WIDTH+1:2]), MWriteData, MReadData, DataMem_Ready,
//        MemErr (only when DMEM_RANGE_CHECK_EN is defined: out-of-range access flag).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ReadEnable,
    input  logic [3:0]  WriteEnable,
    input  logic [31:0] Address,
    input  logic [31:0] MWriteData,
    output logic [31:0] MReadData,
    output logic        DataMem_Ready
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic        MemErr
`endif
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > DMEM_MAX_WAIT) begin : g_bad_wait
        $error("WAIT_CYCLES out of range");
    end

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [31:0]           wdata_q;
    logic [3:0]            we_q;
    logic                  re_q;
    logic                  oob_q;
    logic                  ready_q;
    logic                  err_q;
    logic                  err_rd_q;
    logic [31:0]           ram_rdata;
    logic                  req;
    logic                  oob;
    logic                  access;
    logic                  unused_addr;

    assign req    = ReadEnable | (|WriteEnable);
    assign access = state_q == S_ACCESS;

`ifdef DMEM_RANGE_CHECK_EN
    assign oob    = (Address >> (ADDR_WIDTH + 2)) != 32'd0;
    assign MemErr = err_q;
`else
    assign oob    = 1'b0;
`endif
    assign unused_addr = ^{Address, err_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            wdata_q  <= '0;
            we_q     <= '0;
            re_q     <= 1'b0;
            oob_q    <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            err_rd_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (req) begin
                    word_q  <= Address[ADDR_WIDTH+1:2];
                    wdata_q <= MWriteData;
                    we_q    <= WriteEnable;
                    re_q    <= ReadEnable;
                    oob_q   <= oob;
                    cnt_q   <= WAIT_LOAD;
                    state_q <= WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT;
                end
                S_WAIT: begin
                    cnt_q   <= cnt_q - 4'd1;
                    state_q <= cnt_q == 4'd0 ? S_ACCESS : S_WAIT;
                end
                S_ACCESS: begin
                    state_q <= S_RESP;
                    ready_q <= 1'b1;
                    err_q   <= oob_q;
                    // The error pattern sticks until the next in-range read replaces it.
                    if (re_q) err_rd_q <= oob_q;
                end
                S_RESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    dmem_sram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
        .clk_i   (clock),
        .rst_n_i (reset_n),
        .addr_i  (word_q),
        .we_i    (access && !oob_q ? we_q : 4'b0000),
        .re_i    (access && re_q && !oob_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign MReadData     = err_rd_q ? DMEM_ERR_PATTERN : ram_rdata;
    assign DataMem_Ready = ready_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized self-checking bench against a word-array reference model.
module tb_data_mem_responder;
    localparam int AW = 10;
    localparam int W  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  we = 4'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        rdy;
    logic        re0 = 1'b0;
    logic [3:0]  we0 = 4'b0;
    logic [31:0] addr0 = '0;
    logic [31:0] wd0 = '0;
    logic [31:0] rd0;
    logic        rdy0;
`ifdef DMEM_RANGE_CHECK_EN
    logic        err;
    logic        err0;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clock(clk), .reset_n(rst_n), .ReadEnable(re), .WriteEnable(we),
        .Address(addr), .MWriteData(wd), .MReadData(rd), .DataMem_Ready(rdy)
`ifdef DMEM_RANGE_CHECK_EN
        , .MemErr(err)
`endif
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
        .clock(clk), .reset_n(rst_n), .ReadEnable(re0), .WriteEnable(we0),
        .Address(addr0), .MWriteData(wd0), .MReadData(rd0), .DataMem_Ready(rdy0)
`ifdef DMEM_RANGE_CHECK_EN
        , .MemErr(err0)
`endif
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_tx = 0;
    int          pulses = 0;
    int          consec = 0;
    logic        prev_rdy = 1'b0;
    logic [31:0] mem_m [1024];
    logic [31:0] last_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_oob(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return (a >> (AW + 2)) != 0;
`else
        return a == 32'hFFFF_FFFF && a != 32'hFFFF_FFFF;
`endif
    endfunction

    always @(negedge clk) begin
        if (rdy) pulses++;
        if (rdy && prev_rdy) consec++;
        prev_rdy = rdy;
    end

    // One complete request on the main instance: Ready must appear exactly 2+W
    // cycles after the request is first sampled, with the model's read data.
    task automatic xact(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        int   idx;
        logic o;
        idx = int'((a >> 2) % 1024);
        o = is_oob(a);
        if (!o)
            for (int i = 0; i < 4; i++)
                if (w[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
        if (r) last_rd = o ? 32'hDEAD_BEEF : mem_m[idx];
        n_tx++;
        @(posedge clk); #1;
        re = r; we = w; addr = a; wd = d;
        for (int c = 1; c <= 2 + W; c++) begin
            @(posedge clk); #1;
            chk("ready_timing", 32'(rdy), 32'(c == 2 + W));
            if (c == 2 + W) begin
                chk("rdata", rd, last_rd);
`ifdef DMEM_RANGE_CHECK_EN
                chk("memerr", 32'(err), 32'(o));
`endif
            end
            addr = $urandom;
            wd = $urandom;
        end
        @(posedge clk); #1;
        re = 1'b0; we = 4'b0;
        chk("ready_after_resp", 32'(rdy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_ready", 32'(rdy), 32'd0);
            chk("idle_rdata", rd, 32'd0);
        end
        for (int i = 0; i < 16; i++) xact(1'b0, 4'hF, 32'(i * 4), 32'd0);

        xact(1'b0, 4'hF, 32'h10, 32'h1234_5678);
        xact(1'b1, 4'h0, 32'h10, 32'd0);
        chk("full_word", rd, 32'h1234_5678);
        xact(1'b0, 4'b0100, 32'h13, 32'h00AB_0000);
        chk("write_only_keeps", rd, 32'h1234_5678);
        xact(1'b1, 4'h0, 32'h12, 32'd0);
        chk("byte_lane", rd, 32'h12AB_5678);
        xact(1'b1, 4'b0011, 32'h10, 32'h0000_9ABC);
        chk("write_then_read", rd, 32'h12AB_9ABC);

        // Reset during WAIT of a write: the write and its Ready are lost.
        @(posedge clk); #1;
        re = 1'b0; we = 4'hF; addr = 32'h20; wd = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_rdata", rd, 32'd0);
        last_rd = 32'd0;
        we = 4'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_ready", 32'(rdy), 32'd0);
        end
        xact(1'b1, 4'h0, 32'h20, 32'd0);
        chk("rst_write_lost", rd, 32'd0);

`ifdef DMEM_RANGE_CHECK_EN
        xact(1'b0, 4'hF, 32'h1000, 32'h1111_1111);
        xact(1'b1, 4'h0, 32'h1000, 32'd0);
        chk("oob_pattern", rd, 32'hDEAD_BEEF);
        xact(1'b1, 4'h0, 32'h0, 32'd0);
        chk("oob_no_write", rd, mem_m[0]);
`endif

        for (int t = 0; t < 60; t++) begin
            logic        r;
            logic [3:0]  w;
            logic [31:0] a;
            r = 1'($urandom_range(0, 1));
            w = 4'($urandom);
            if (!r && w == 4'b0) r = 1'b1;
            a = 32'($urandom_range(0, 15)) << 2 | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << 12);
            xact(r, w, a, $urandom);
        end

        // Zero-wait instance: Ready two cycles after the request is sampled.
        @(posedge clk); #1;
        re0 = 1'b0; we0 = 4'hF; addr0 = 32'h10; wd0 = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("w0_ready_k1", 32'(rdy0), 32'd0);
        @(posedge clk); #1;
        chk("w0_ready_k2", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        we0 = 4'b0;
        chk("w0_ready_drop", 32'(rdy0), 32'd0);
        @(posedge clk); #1;
        re0 = 1'b1; addr0 = 32'h11;
        @(posedge clk); #1;
        chk("r0_ready_k1", 32'(rdy0), 32'd0);
        @(posedge clk); #1;
        chk("r0_ready_k2", 32'(rdy0), 32'd1);
        chk("r0_rdata", rd0, 32'hCAFE_F00D);
        @(posedge clk); #1;
        re0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("r0_single_pulse", 32'(rdy0), 32'd0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("pulse_count", 32'(pulses), 32'(n_tx));
        chk("no_consecutive_ready", 32'(consec), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
